// File: rtl/cpu_gen_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states and instruction-field helpers.
// Helpers take the packed instruction zero-extended to 32 bits plus the RW/ADDR_W field widths.
package cpu_gen_pkg;

  localparam logic [3:0] OP_SUB   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_LDI   = 4'd5;
  localparam logic [3:0] OP_LOAD  = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;
  localparam logic [3:0] OP_BEQZ  = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  localparam int MAX_INSTR_W = 32;
  typedef logic [MAX_INSTR_W-1:0] instr_word_t;

  function automatic logic [3:0] instr_opcode(input instr_word_t ir, input int rw, input int aw);
    instr_word_t sh;
    sh = ir >> (2 * rw + aw);
    return sh[3:0];
  endfunction

  function automatic instr_word_t instr_rd(input instr_word_t ir, input int rw, input int aw);
    return (ir >> (rw + aw)) & ((instr_word_t'(1) << rw) - instr_word_t'(1));
  endfunction

  function automatic instr_word_t instr_rs(input instr_word_t ir, input int rw, input int aw);
    return (ir >> aw) & ((instr_word_t'(1) << rw) - instr_word_t'(1));
  endfunction

  function automatic instr_word_t instr_imm(input instr_word_t ir, input int aw);
    return ir & ((instr_word_t'(1) << aw) - instr_word_t'(1));
  endfunction

endpackage

// File: rtl/cpu_gen_alu.sv
// Combinational ALU: SUB/ADD/AND/OR/XOR with carry (borrow on SUB) and zero flags.
// No latency or backpressure; opcodes outside the ALU set yield a zero result.
module cpu_gen_alu
  import cpu_gen_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] wide;

  // The extra top bit carries out of ADD and is the borrow of SUB (b > a).
  always_comb begin
    wide = '0;
    case (op)
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      default: wide = '0;
    endcase
    result = wide[DATA_W-1:0];
    carry  = wide[DATA_W];
    zero   = (wide[DATA_W-1:0] == '0);
  end

endmodule

// File: rtl/cpu_core_gen.sv
// Multi-cycle core: FETCH -> EXEC (-> MEM) per instruction, 2 cycles for ALU/branch, 3 for LOAD/STORE.
// imem/dmem req is held stable until the matching ready; each wait cycle adds one cycle.
module cpu_core_gen
  import cpu_gen_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int ADDR_W  = 5,
  parameter  int REG_CNT = 4,
  localparam int RW      = $clog2(REG_CNT),
  localparam int INSTR_W = 4 + 2 * RW + ADDR_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start_execution,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ready,
  output logic [DATA_W-1:0]  alu_out,
  output logic               carry,
  output logic               zero,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc_out
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   regs [REG_CNT];
  logic                req_pend;

  instr_word_t         ir_ext;
  logic [3:0]          opcode;
  logic [RW-1:0]       rd, rs;
  logic [ADDR_W-1:0]   imm;
  logic [DATA_W-1:0]   rd_val, rs_val, alu_res;
  logic                alu_c, alu_z;
  logic                fetch_done, mem_done;

  assign ir_ext = instr_word_t'(ir);
  assign opcode = instr_opcode(ir_ext, RW, ADDR_W);
  assign rd     = RW'(instr_rd(ir_ext, RW, ADDR_W));
  assign rs     = RW'(instr_rs(ir_ext, RW, ADDR_W));
  assign imm    = ADDR_W'(instr_imm(ir_ext, ADDR_W));
  assign rd_val = regs[rd];
  assign rs_val = regs[rs];

  // A raised fetch request is held by req_pend even if the run enable drops.
  assign imem_req   = (state == FETCH) && (start_execution || req_pend);
  assign imem_addr  = pc;
  assign fetch_done = imem_req && imem_ready;

  assign dmem_req   = (state == MEM);
  assign dmem_we    = (state == MEM) && (opcode == OP_STORE);
  assign dmem_addr  = (state == MEM) ? imm : '0;
  assign dmem_wdata = (state == MEM) ? rs_val : '0;
  assign mem_done   = dmem_req && dmem_ready;
  assign pc_out     = pc;

  cpu_gen_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (rd_val),
    .b      (rs_val),
    .op     (opcode),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (fetch_done) state_nxt = EXEC;
      EXEC: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = MEM;
          OP_HALT:           state_nxt = HALT;
          default:           state_nxt = FETCH;
        endcase
      end
      MEM:     if (mem_done) state_nxt = FETCH;
      default: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= '0;
      ir       <= '0;
      alu_out  <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      halted   <= 1'b0;
      req_pend <= 1'b0;
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else begin
      req_pend <= imem_req && !imem_ready;
      if (fetch_done) ir <= imem_rdata;
      if (state == EXEC) begin
        case (opcode)
          OP_SUB, OP_ADD, OP_AND, OP_OR, OP_XOR: begin
            regs[rd] <= alu_res;
            alu_out  <= alu_res;
            carry    <= alu_c;
            zero     <= alu_z;
            pc       <= pc + ADDR_W'(1);
          end
          OP_LDI: begin
            regs[rd] <= DATA_W'(imm);
            alu_out  <= DATA_W'(imm);
            pc       <= pc + ADDR_W'(1);
          end
          OP_LOAD, OP_STORE: ;
          OP_BEQZ: pc <= (rd_val == '0) ? imm : pc + ADDR_W'(1);
          OP_JMP:  pc <= imm;
          OP_HALT: halted <= 1'b1;
          default: pc <= pc + ADDR_W'(1);
        endcase
      end
      if (mem_done) begin
        if (!dmem_we) regs[rd] <= dmem_rdata;
        pc <= pc + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_core_gen.sv
// Bench for cpu_core_gen: table of instructions with hand-computed results on the default core,
// plus sequences for reset, run-enable, halt and a 16-bit/8-register instance.
module tb_cpu_core_gen;
  import cpu_gen_pkg::*;

  localparam int IW = 13;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n, start_execution;
  logic          imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, carry, zero, halted;
  logic [4:0]    imem_addr, dmem_addr, pc_out;
  logic [IW-1:0] imem_rdata;
  logic [7:0]    dmem_wdata, dmem_rdata, alu_out;

  logic          b_start, b_imem_req, b_dmem_req, b_dmem_we, b_carry, b_zero, b_halted;
  logic [5:0]    b_imem_addr, b_dmem_addr, b_pc_out;
  logic [15:0]   b_imem_rdata, b_dmem_wdata, b_dmem_rdata, b_alu_out;

  cpu_core_gen dut0 (
    .clock(clock), .reset_n(reset_n), .start_execution(start_execution),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .alu_out(alu_out), .carry(carry),
    .zero(zero), .halted(halted), .pc_out(pc_out)
  );

  cpu_core_gen #(.DATA_W(16), .ADDR_W(6), .REG_CNT(8)) dut1 (
    .clock(clock), .reset_n(reset_n), .start_execution(b_start),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata), .imem_ready(b_imem_req),
    .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata),
    .dmem_rdata(b_dmem_rdata), .dmem_ready(b_dmem_req), .alu_out(b_alu_out), .carry(b_carry),
    .zero(b_zero), .halted(b_halted), .pc_out(b_pc_out)
  );

  // Memory models with programmable wait states for the default core.
  logic [IW-1:0] imem [32];
  logic [7:0]    dmem [32];
  logic [15:0]   b_imem [64];
  logic [15:0]   b_dmem [64];
  int imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0, cyc = 0, fetch_cyc = 0;

  assign imem_rdata   = imem[imem_addr];
  assign imem_ready   = imem_req && (icnt >= imem_wait);
  assign dmem_rdata   = dmem[dmem_addr];
  assign dmem_ready   = dmem_req && (dcnt >= dmem_wait);
  assign b_imem_rdata = b_imem[b_imem_addr];
  assign b_dmem_rdata = b_dmem[b_dmem_addr];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    if (b_dmem_req && b_dmem_we) b_dmem[b_dmem_addr] <= b_dmem_wdata;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Request outputs must hold while the memory is stalling.
  logic       prev_dwait = 1'b0, prev_iwait = 1'b0, prev_we = 1'b0;
  logic [4:0] prev_daddr = '0, prev_iaddr = '0;
  logic [7:0] prev_wdata = '0;
  always @(negedge clock) begin
    if (prev_dwait && dmem_req) begin
      chk("dmem_addr_stable", 32'(dmem_addr), 32'(prev_daddr));
      chk("dmem_wdata_stable", 32'(dmem_wdata), 32'(prev_wdata));
      chk("dmem_we_stable", 32'(dmem_we), 32'(prev_we));
    end
    if (prev_iwait && imem_req) chk("imem_addr_stable", 32'(imem_addr), 32'(prev_iaddr));
    prev_dwait = dmem_req && !dmem_ready;
    prev_iwait = imem_req && !imem_ready;
    prev_daddr = dmem_addr;
    prev_wdata = dmem_wdata;
    prev_we    = dmem_we;
    prev_iaddr = imem_addr;
  end

  function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs, input int imm);
    return {4'(op), 2'(rd), 2'(rs), 5'(imm)};
  endfunction

  function automatic logic [15:0] enc16(input int op, input int rd, input int rs, input int imm);
    return {4'(op), 3'(rd), 3'(rs), 6'(imm)};
  endfunction

  typedef struct {
    logic [4:0] addr;
    int op, rd, rs, imm, iw, dw;
    logic [4:0] exp_pc;
    logic [7:0] exp_alu;
    logic exp_c, exp_z;
    logic [1:0] ri;
    logic [7:0] exp_reg;
    int gap;
  } vec_t;

  function automatic vec_t mv(int a, int op, int rd, int rs, int imm, int iw, int dw,
                              int pc, int alu, int c, int z, int ri, int rv, int gap);
    vec_t v;
    v.addr = 5'(a); v.op = op; v.rd = rd; v.rs = rs; v.imm = imm; v.iw = iw; v.dw = dw;
    v.exp_pc = 5'(pc); v.exp_alu = 8'(alu); v.exp_c = 1'(c); v.exp_z = 1'(z);
    v.ri = 2'(ri); v.exp_reg = 8'(rv); v.gap = gap;
    return v;
  endfunction

  // Wait for one fetch handshake, then for the core to be back in FETCH or HALT.
  task automatic step(output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (!(imem_req && imem_ready)) begin
      n++;
      if (n > 60) begin ok = 1'b0; return; end
      @(negedge clock);
    end
    fetch_cyc = cyc;
    @(negedge clock);
    while (!(dut0.state == FETCH || dut0.state == HALT)) begin
      n++;
      if (n > 60) begin ok = 1'b0; return; end
      @(negedge clock);
    end
  endtask

  localparam int NV = 19;
  vec_t vt [NV];
  bit   ok;
  int   prev_fetch, n;

  initial begin
    //          addr op  rd rs imm iw dw  pc  alu  c  z  ri rv   gap
    vt[0]  = mv(0,   5,  1, 0, 5,  0, 0,  1,  5,   0, 0, 1, 5,    0);
    vt[1]  = mv(1,   5,  2, 0, 3,  0, 0,  2,  3,   0, 0, 2, 3,    2);
    vt[2]  = mv(2,   0,  1, 2, 0,  0, 0,  3,  2,   0, 0, 1, 2,    2);
    vt[3]  = mv(3,   1,  1, 2, 0,  0, 0,  4,  5,   0, 0, 1, 5,    2);
    vt[4]  = mv(4,   5,  1, 0, 3,  0, 0,  5,  3,   0, 0, 1, 3,    0);
    vt[5]  = mv(5,   5,  2, 0, 5,  0, 0,  6,  5,   0, 0, 2, 5,    0);
    vt[6]  = mv(6,   0,  1, 2, 0,  0, 0,  7,  'hFE, 1, 0, 1, 'hFE, 0);
    vt[7]  = mv(7,   4,  1, 1, 0,  0, 0,  8,  0,   0, 1, 1, 0,    0);
    vt[8]  = mv(8,   3,  1, 2, 0,  0, 0,  9,  5,   0, 0, 1, 5,    0);
    vt[9]  = mv(9,   5,  2, 0, 3,  0, 0,  10, 3,   0, 0, 2, 3,    0);
    vt[10] = mv(10,  2,  1, 2, 0,  0, 0,  11, 1,   0, 0, 1, 1,    0);
    vt[11] = mv(11,  7,  0, 2, 7,  3, 2,  12, 1,   0, 0, 2, 3,    0);
    vt[12] = mv(12,  6,  3, 0, 7,  3, 2,  13, 1,   0, 0, 3, 3,    8);
    vt[13] = mv(13,  5,  0, 0, 0,  0, 0,  14, 0,   0, 0, 0, 0,    0);
    vt[14] = mv(14,  8,  0, 0, 20, 0, 0,  20, 0,   0, 0, 0, 0,    0);
    vt[15] = mv(20,  8,  1, 0, 25, 0, 0,  21, 0,   0, 0, 1, 1,    0);
    vt[16] = mv(21,  12, 0, 0, 0,  0, 0,  22, 0,   0, 0, 1, 1,    0);
    vt[17] = mv(22,  9,  0, 0, 31, 0, 0,  31, 0,   0, 0, 3, 3,    0);
    vt[18] = mv(31,  14, 0, 0, 0,  0, 0,  0,  0,   0, 0, 2, 3,    0);

    for (int a = 0; a < 32; a++) imem[a] = enc(10, 0, 0, 0);
    for (int i = 0; i < NV; i++) imem[vt[i].addr] = enc(vt[i].op, vt[i].rd, vt[i].rs, vt[i].imm);
    for (int a = 0; a < 64; a++) b_imem[a] = enc16(10, 0, 0, 0);
    b_imem[0] = enc16(5, 7, 0, 0);
    b_imem[1] = enc16(5, 6, 0, 1);
    b_imem[2] = enc16(0, 7, 6, 0);
    b_imem[3] = enc16(7, 0, 7, 40);
    b_imem[4] = enc16(1, 7, 6, 0);
    b_imem[5] = enc16(15, 0, 0, 0);

    start_execution = 1'b0;
    b_start = 1'b0;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    chk("rst_pc", 32'(pc_out), 0);
    chk("rst_alu", 32'(alu_out), 0);
    chk("rst_flags", 32'({carry, zero, halted}), 0);
    chk("rst_req", 32'({imem_req, dmem_req, dmem_we}), 0);
    chk("rst_daddr_wdata", 32'({dmem_addr, dmem_wdata}), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Table-driven program on the default core.
    start_execution = 1'b1;
    for (int i = 0; i < NV; i++) begin
      imem_wait = vt[i].iw;
      dmem_wait = vt[i].dw;
      #1;
      prev_fetch = fetch_cyc;
      step(ok);
      chk($sformatf("v%0d_progress", i), 32'(ok), 1);
      chk($sformatf("v%0d_pc", i), 32'(pc_out), 32'(vt[i].exp_pc));
      chk($sformatf("v%0d_alu_out", i), 32'(alu_out), 32'(vt[i].exp_alu));
      chk($sformatf("v%0d_carry", i), 32'(carry), 32'(vt[i].exp_c));
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vt[i].exp_z));
      chk($sformatf("v%0d_reg", i), 32'(dut0.regs[vt[i].ri]), 32'(vt[i].exp_reg));
      if (vt[i].gap != 0) chk($sformatf("v%0d_fetch_gap", i), 32'(fetch_cyc - prev_fetch), 32'(vt[i].gap));
    end
    chk("store_mem7", 32'(dmem[7]), 3);

    // Reset values, run enable held low, then reset pulsed during a stalled store.
    start_execution = 1'b0;
    reset_n = 1'b0;
    imem_wait = 0;
    dmem_wait = 10;
    imem[0] = enc(5, 1, 0, 9);
    imem[1] = enc(7, 0, 1, 5);
    #1;
    chk("rst2_regs", 32'({dut0.regs[1], dut0.regs[2], dut0.regs[3]}), 0);
    chk("rst2_pc", 32'(pc_out), 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("idle_imem_req", 32'(imem_req), 0);
      chk("idle_pc", 32'(pc_out), 0);
    end
    start_execution = 1'b1;
    #1;
    chk("start_imem_req", 32'(imem_req), 1);
    step(ok);
    chk("ldi9_progress", 32'(ok), 1);
    chk("ldi9_r1", 32'(dut0.regs[1]), 9);
    n = 0;
    while (!dmem_req && n < 20) begin @(negedge clock); n++; end
    chk("store_req_seen", 32'(dmem_req), 1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midmem_dmem_req", 32'(dmem_req), 0);
    chk("midmem_pc", 32'(pc_out), 0);
    chk("midmem_r1", 32'(dut0.regs[1]), 0);
    start_execution = 1'b0;
    @(negedge clock);
    chk("midmem_no_write", 32'(dmem[5]), 0);

    // A raised fetch request persists after the run enable drops.
    imem_wait = 3;
    reset_n = 1'b1;
    @(negedge clock);
    start_execution = 1'b1;
    #1;
    chk("hold_req_up", 32'(imem_req), 1);
    @(negedge clock);
    start_execution = 1'b0;
    #1;
    chk("hold_req_kept", 32'(imem_req), 1);
    repeat (6) @(negedge clock);
    chk("hold_after_pc", 32'(pc_out), 1);
    chk("hold_after_req", 32'(imem_req), 0);
    chk("hold_after_r1", 32'(dut0.regs[1]), 9);

    // HALT at address 0.
    reset_n = 1'b0;
    imem_wait = 0;
    imem[0] = enc(15, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start_execution = 1'b1;
    #1;
    chk("halt_fetch_req", 32'(imem_req), 1);
    @(negedge clock);
    chk("halt_exec_halted", 32'(halted), 0);
    @(negedge clock);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_pc", 32'(pc_out), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("halt_imem_req", 32'(imem_req), 0);
    end

    // Wide instance: 0xFFFF + 1 wraps with carry and zero, r7 addressable.
    b_start = 1'b1;
    n = 0;
    while (!b_halted && n < 100) begin @(negedge clock); n++; end
    chk("w_halted", 32'(b_halted), 1);
    chk("w_store_ffff", 32'(b_dmem[40]), 32'h0000_FFFF);
    chk("w_alu_out", 32'(b_alu_out), 0);
    chk("w_carry_zero", 32'({b_carry, b_zero}), 3);
    chk("w_r7", 32'(dut1.regs[7]), 0);
    chk("w_r6", 32'(dut1.regs[6]), 1);
    chk("w_pc", 32'(b_pc_out), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cpu_core_gen.md
# cpu_core_gen

Parametrised multi-cycle processor core, the next generation of the team's 8-bit four-register core. Data width, register count and address width are configurable. Instruction and data memory are split into two ports, each with a req/ready handshake, so wait states are tolerated. Adds immediate load, branch, jump, halt and carry/zero flags, and sits between the instruction ROM/RAM and the data RAM in the processor top level.

## Interface
Parameters:
- DATA_W, 8: data path, register and data-memory word width (≥2).
- ADDR_W, 5: instruction and data address width; also the immediate width.
- REG_CNT, 4: register count; power of two, ≥2. RW = clog2(REG_CNT).
- INSTR_W is derived as 4 + 2·RW + ADDR_W (13 at defaults). Format, MSB first: opcode[3:0], rd[RW], rs[RW], imm[ADDR_W].

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_execution  in  1  run enable, sampled in FETCH only.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_rdata  in  INSTR_W  instruction word, valid when imem_ready.
- imem_ready  in  1  fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  data address (= imm).
- dmem_wdata  out  DATA_W  store data (= reg[rs]).
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready.
- dmem_ready  in  1  data access complete.
- alu_out  out  DATA_W  last ALU/LDI result.
- carry, zero  out  1 each  flags.
- halted  out  1  core in HALT.
- pc_out  out  ADDR_W  current program counter.

## Operation
- Reset (async, immediate): pc, all registers, IR, alu_out, carry, zero and halted are 0; all req/we outputs are 0; addr/wdata outputs are 0; state = FETCH.
- FETCH: if start_execution=1, assert imem_req with imem_addr=pc. On a cycle with imem_req && imem_ready, latch imem_rdata into IR and go to EXEC. If start_execution=0, imem_req=0 and the state holds. Once a request is raised, it stays up until ready, regardless of start_execution.
- EXEC, by opcode:
  - 0 SUB, 1 ADD, 2 AND, 3 OR, 4 XOR: result = reg[rd] op reg[rs]. Write it to reg[rd] and alu_out in the same edge. zero = (result==0). carry = ADD carry-out or SUB borrow (reg[rs] > reg[rd]); logic ops clear carry. Then pc+1, FETCH.
  - 5 LDI: reg[rd] = zero-extended imm, also written to alu_out. Flags unchanged. Then pc+1, FETCH.
  - 6 LOAD / 7 STORE: go to MEM.
  - 8 BEQZ: pc = imm if reg[rd]==0, else pc+1. Then FETCH.
  - 9 JMP: pc = imm, FETCH.
  - 15 HALT: halted = 1, go to HALT; pc is not advanced.
  - 10–14: NOP; pc+1, FETCH.
- MEM: assert dmem_req. dmem_we = (opcode==STORE), dmem_addr = imm, dmem_wdata = reg[rs]. All are held stable until dmem_ready. On the ready cycle, a LOAD writes dmem_rdata to reg[rd]. Flags unchanged. Then pc+1, FETCH.
- HALT: terminal; exited only by reset_n.
- pc increments wrap modulo 2^ADDR_W. rd == rs is legal: operands are read before the write. There is no register hardwired to zero.

## Timing
- imem_ready/dmem_ready are accepted in the same cycle as req (zero-wait). Each wait cycle adds one cycle of latency.
- Zero-wait latency: ALU/LDI/branch/NOP take 2 cycles (FETCH, EXEC); LOAD/STORE take 3 cycles; HALT asserts halted 2 cycles after its fetch request.
- Outputs are registered, except that req/addr/wdata may be decoded from state and registers without combinational paths from inputs.
- A ready input that is high while the matching req is low is ignored.
- Reset asserted mid-request drops the req output asynchronously; no write completes.

## Structure
- Package cpu_gen_pkg holds:
  - opcode localparams (OP_SUB … OP_HALT);
  - the state encoding FETCH/EXEC/MEM/HALT;
  - field-extraction helpers parametrised on RW/ADDR_W.
- Sub-module cpu_gen_alu is combinational: operands a, b (DATA_W) and opcode in; result, carry and zero out. The core instantiates it once.
- The register file is an internal array in the core.

## Test plan
- Defaults, zero-wait: LDI r1,5; LDI r2,3; SUB r1,r2 → r1=2, alu_out=2, zero=0, carry=0; ADD issued 2 cycles after SUB's fetch.
- Borrow/zero: r1=3, r2=5; SUB r1,r2 → r1=0xFE, carry=1. Then XOR r1,r1 → r1=0, zero=1, carry=0.
- Wait states: imem_ready delayed 3 cycles and dmem_ready delayed 2. STORE r2→addr 7, then LOAD r3←addr 7 → mem[7]=3, r3=3. dmem_addr and dmem_wdata stay stable while waiting.
- Control flow: LDI r0,0; BEQZ r0,20 → pc=20. At pc=31 a NOP wraps pc to 0. A HALT sets halted=1, after which imem_req stays 0.
- start_execution low in FETCH holds pc and keeps imem_req=0. Reset_n pulsed during MEM clears dmem_req immediately and returns pc=0 and all registers to 0.
- DATA_W=16, REG_CNT=8, ADDR_W=6: ADD 0xFFFF+1 → 0x0000 with carry=1 and zero=1; r7 is addressable.
